// File: rtl/instruction_fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer: FSM states,
// the NOP encoding returned for out-of-range fetches and default sizes.
package instruction_fetch_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0 -- handed to the consumer instead of garbage when the PC
    // points past the end of instruction memory.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int RESET_PC_DEFAULT   = 0;
    localparam int FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/instruction_fetch_buffer_fifo.sv
// Prefetch buffer: a power-of-two circular FIFO with a synchronous flush.
// Pushes into a full buffer and pops from an empty one are ignored, so an
// entry is never overwritten or lost. Flush wins over a same-cycle push.
module fetch_fifo
    import instruction_fetch_buffer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;

    // Next pointer/occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Instruction fetch unit: inline instruction memory with 1-cycle synchronous
// read, a PC/FSM that issues reads while the prefetch buffer has room, and
// redirect handling (flush, realign, epoch-tagged discard of stale reads).
//
// Handshake: an instruction moves to the consumer on every rising edge where
// instrValid && instrReady; instrValid never depends on instrReady and the
// head stays stable until it is taken.
module instruction_fetch_buffer
    import instruction_fetch_buffer_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              MEM_DEPTH  = 1024,
    parameter int              FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            fetchEnable,
    input  logic            redirectValid,
    input  logic [XLEN-1:0] redirectPc,
    input  logic            progWriteEnable,
    input  logic [XLEN-1:0] progAddress,
    input  logic [XLEN-1:0] progData,
    output logic            instrValid,
    input  logic            instrReady,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instrPc,
    output logic            fetchFault,
    output logic            alignError,
    output logic [1:0]      fsmState
);

    localparam int              AW        = $clog2(MEM_DEPTH);
    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int              EW        = 2 * XLEN + 1;
    localparam logic [XLEN:0]   MEM_BYTES = (XLEN+1)'(MEM_DEPTH) << 2;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            epoch_q, epoch_d;
    logic            inflight_q, inflight_d;
    logic            inflight_epoch_q, inflight_epoch_d;
    logic            align_q, align_d;

    logic [XLEN-1:0] mem_q [MEM_DEPTH];
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic            rsp_fault_q;

    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   wr_idx;
    logic            pc_fault;
    logic            prog_in_range;
    logic            unused_prog_lsbs;

    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occupancy;
    logic            fifo_empty;
    logic [EW-1:0]   fifo_head;
    logic [EW-1:0]   push_data;
    logic            rsp_push;
    logic            issue;
    logic            transfer;

    assign rd_idx           = pc_q[AW+1:2];
    assign wr_idx           = progAddress[AW+1:2];
    assign pc_fault         = ({1'b0, pc_q} >= MEM_BYTES);
    assign prog_in_range    = ({1'b0, progAddress} < MEM_BYTES);
    assign unused_prog_lsbs = ^progAddress[1:0];

    // Reserve a buffer slot for the read in flight so a full buffer never
    // receives a response it cannot hold.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign issue     = (state_q == FETCH) && fetchEnable && !redirectValid &&
                       (occupancy < (CW+1)'(FIFO_DEPTH));

    // A response belongs to the current fetch stream only if its epoch matches
    // and no redirect is flushing the buffer this cycle.
    assign rsp_push  = inflight_q && (inflight_epoch_q == epoch_q) && !redirectValid;
    assign push_data = {rsp_fault_q, rsp_pc_q,
                        rsp_fault_q ? XLEN'(NOP_INSTR) : rdata_q};

    assign instrValid = !fifo_empty;
    assign transfer   = instrValid && instrReady;

    // FSM next-state; a redirect leaves the state where it is.
    always_comb begin
        state_d = state_q;
        if (!redirectValid) begin
            case (state_q)
                IDLE:    if (fetchEnable) state_d = FETCH;
                FETCH:   if (!fetchEnable) state_d = DRAIN;
                DRAIN: begin
                    if (fetchEnable)      state_d = FETCH;
                    else if (!inflight_q) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // PC, epoch, in-flight tracking and misalignment pulse.
    always_comb begin
        pc_d             = pc_q;
        epoch_d          = epoch_q;
        inflight_d       = issue;
        inflight_epoch_d = epoch_q;
        align_d          = redirectValid && (redirectPc[1:0] != 2'b00);
        if (redirectValid) begin
            pc_d       = {redirectPc[XLEN-1:2], 2'b00};
            epoch_d    = ~epoch_q;
            inflight_d = 1'b0;
        end else if (issue) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q          <= IDLE;
            pc_q             <= RESET_PC;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
            align_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            epoch_q          <= epoch_d;
            inflight_q       <= inflight_d;
            inflight_epoch_q <= inflight_epoch_d;
            align_q          <= align_d;
        end
    end

    // Instruction memory: load port plus registered read (old data on collision).
    always_ff @(posedge clk) begin
        if (progWriteEnable && prog_in_range) mem_q[wr_idx] <= progData;
        if (issue) begin
            rdata_q     <= mem_q[rd_idx];
            rsp_pc_q    <= pc_q;
            rsp_fault_q <= pc_fault;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (resetN),
        .flush_i     (redirectValid),
        .push_i      (rsp_push),
        .push_data_i (push_data),
        .pop_i       (transfer),
        .head_data_o (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Stale storage never leaks out: the head fields read as zero while empty.
    assign {fetchFault, instrPc, instruction} = instrValid ? fifo_head : '0;
    assign alignError = align_q;
    assign fsmState   = state_q;

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Directed bench for instruction_fetch_buffer: streaming, back-pressure,
// redirects (aligned, misaligned, out of range) and mid-stream reset.
module tb_instruction_fetch_buffer;
    import instruction_fetch_buffer_pkg::*;

    localparam int XLEN       = 32;
    localparam int MEM_DEPTH  = 1024;
    localparam int FIFO_DEPTH = 4;

    logic            clk;
    logic            resetN;
    logic            fetchEnable;
    logic            redirectValid;
    logic [XLEN-1:0] redirectPc;
    logic            progWriteEnable;
    logic [XLEN-1:0] progAddress;
    logic [XLEN-1:0] progData;
    logic            instrValid;
    logic            instrReady;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] instrPc;
    logic            fetchFault;
    logic            alignError;
    logic [1:0]      fsmState;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected transfers: {fault, pc, instruction}
    logic [2*XLEN:0] exp_q[$];

    instruction_fetch_buffer #(
        .XLEN       (XLEN),
        .MEM_DEPTH  (MEM_DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .fetchEnable     (fetchEnable),
        .redirectValid   (redirectValid),
        .redirectPc      (redirectPc),
        .progWriteEnable (progWriteEnable),
        .progAddress     (progAddress),
        .progData        (progData),
        .instrValid      (instrValid),
        .instrReady      (instrReady),
        .instruction     (instruction),
        .instrPc         (instrPc),
        .fetchFault      (fetchFault),
        .alignError      (alignError),
        .fsmState        (fsmState)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetchEnable     = 1'b0;
        instrReady      = 1'b0;
        redirectValid   = 1'b0;
        redirectPc      = '0;
        progWriteEnable = 1'b0;
        progAddress     = '0;
        progData        = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    task automatic prog_write(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data);
        progWriteEnable = 1'b1;
        progAddress     = addr;
        progData        = data;
        tick();
        progWriteEnable = 1'b0;
    endtask

    task automatic exp_push(input logic fault, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr);
        exp_q.push_back({fault, pc, instr});
    endtask

    task automatic redirect(input logic [XLEN-1:0] pc);
        redirectValid = 1'b1;
        redirectPc    = pc;
        tick();
        redirectValid = 1'b0;
    endtask

    // Compare every transfer against the expected queue until n have been
    // seen or the cycle budget runs out.
    task automatic expect_stream(input string tag, input int n, input int budget);
        int got;
        int cyc;
        logic [2*XLEN:0] e;
        got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            if (instrValid && instrReady) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check({tag, "_instr"}, instruction, e[XLEN-1:0]);
                check({tag, "_pc"},    instrPc,     e[2*XLEN-1:XLEN]);
                check({tag, "_fault"}, fetchFault,  e[2*XLEN]);
                got++;
            end
            tick();
            cyc++;
        end
        check({tag, "_count"}, got, n);
    endtask

    initial begin
        idle_inputs();
        resetN = 1'b1;
        #2;
        resetN = 1'b0;
        #1;
        // Reset values, checked before any clock edge.
        check("rst_valid", instrValid, 0);
        check("rst_instr", instruction, 0);
        check("rst_pc",    instrPc, 0);
        check("rst_fault", fetchFault, 0);
        check("rst_align", alignError, 0);
        check("rst_state", fsmState, 64'(IDLE));
        tick();
        tick();
        resetN = 1'b1;

        for (int i = 0; i < 16; i++) prog_write(32'(i * 4), 32'h100 + 32'(i));

        // Streaming: one cycle to enter FETCH, then 2 cycles issue-to-valid.
        instrReady  = 1'b1;
        fetchEnable = 1'b1;
        tick();
        tick();
        check("lat_valid_e2", instrValid, 0);
        tick();
        check("lat_valid_e3", instrValid, 1);
        for (int i = 0; i < 8; i++) exp_push(1'b0, 32'(i * 4), 32'h100 + 32'(i));
        expect_stream("stream", 8, 8);
        fetchEnable = 1'b0;
        tick();
        check("drain_state", fsmState, 64'(DRAIN));
        tick();
        check("idle_state", fsmState, 64'(IDLE));

        // Back-pressure: buffer fills to 4 and PC stops at 0x10.
        apply_reset();
        fetchEnable = 1'b1;
        repeat (10) tick();
        check("bp_count", dut.u_fifo.count_q, 4);
        check("bp_pc",    dut.pc_q, 32'h10);
        check("bp_valid", instrValid, 1);
        check("bp_head",  instruction, 32'h100);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_push(1'b0, 32'(i * 4), 32'h100 + 32'(i));
        instrReady = 1'b1;
        expect_stream("bp", 6, 20);

        // Redirect with 3 buffered and 1 in flight.
        apply_reset();
        fetchEnable = 1'b1;
        repeat (5) tick();
        check("rd_count",    dut.u_fifo.count_q, 3);
        check("rd_inflight", dut.inflight_q, 1);
        redirect(32'h14);
        check("rd_flushed", instrValid, 0);
        check("rd_pc",      dut.pc_q, 32'h14);
        check("rd_align",   alignError, 0);
        check("rd_state",   fsmState, 64'(FETCH));
        exp_q.delete();
        for (int i = 5; i < 8; i++) exp_push(1'b0, 32'(i * 4), 32'h100 + 32'(i));
        instrReady = 1'b1;
        expect_stream("rd", 3, 10);

        // Misaligned redirect.
        apply_reset();
        fetchEnable = 1'b1;
        instrReady  = 1'b1;
        repeat (4) tick();
        redirect(32'h16);
        check("mis_align_pulse", alignError, 1);
        check("mis_flushed",     instrValid, 0);
        exp_q.delete();
        exp_push(1'b0, 32'h14, 32'h105);
        tick();
        check("mis_align_end", alignError, 0);
        expect_stream("mis", 1, 6);

        // Out-of-range redirect returns NOPs flagged as faults.
        redirect(32'(MEM_DEPTH * 4));
        check("oor_align", alignError, 0);
        exp_q.delete();
        exp_push(1'b1, 32'(MEM_DEPTH * 4),     32'h13);
        exp_push(1'b1, 32'(MEM_DEPTH * 4 + 4), 32'h13);
        expect_stream("oor", 2, 8);

        // Reset mid-stream with the buffer full.
        apply_reset();
        fetchEnable = 1'b1;
        repeat (8) tick();
        check("mr_count_full", dut.u_fifo.count_q, 4);
        check("mr_valid_full", instrValid, 1);
        #2;
        resetN = 1'b0;
        #1;
        check("mr_valid", instrValid, 0);
        check("mr_instr", instruction, 0);
        check("mr_pc",    instrPc, 0);
        check("mr_fault", fetchFault, 0);
        check("mr_state", fsmState, 64'(IDLE));
        check("mr_count", dut.u_fifo.count_q, 0);
        tick();
        tick();
        resetN = 1'b1;
        exp_q.delete();
        exp_push(1'b0, 32'h0, 32'h100);
        exp_push(1'b0, 32'h4, 32'h101);
        instrReady = 1'b1;
        expect_stream("mr", 2, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
